mem_port_arbiter: RTL and testbench

// - Shares one single-port 1024x32 memory between the pipeline's instruction-fetch (IF) requester and its data (LW/SW) requester.
// - Sits between the 5-stage pipeline and the memory array.
// - Arbitrates, issues one access at a time, returns read data with a valid pulse, and drops IF returns killed by a taken branch.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// requester and the load/store requester of a 5-stage pipeline. One access is
// in flight at a time (IDLE -> ISSUE -> WAIT -> DONE). Data requests win
// arbitration because a stalled MEM stage holds up the whole pipeline.
// A taken branch (if_flush_i) drops the in-flight fetch return but still lets
// the memory access complete.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a starvation guard.
// After STARVE_MAX back-to-back data grants while a fetch waits, the fetch is
// forced through.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_gnt_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  state_e        state_q;
  logic          ownerIf_q;
  logic          dWe_q;
  logic [2:0]    latCnt_q;
  logic          flush_q;
  logic          if_gnt_q;
  logic          if_valid_q;
  logic [DW-1:0] if_rdata_q;
  logic          d_gnt_q;
  logic          d_valid_q;
  logic [DW-1:0] d_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic grantIf;
  logic grantD;
  logic arbSlot;

  // IDLE and DONE are the only cycles in which a new access may be chosen
  assign arbSlot = (state_q == IDLE) || (state_q == DONE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starveCnt_q;
  logic [3:0] starveCnt_d;

  // Data wins unless the fetch has already been passed over StarveMax times
  always_comb begin
    grantIf = if_req_i && (!d_req_i || (starveCnt_q == StarveMax));
  end

  // Count data grants that overtook a waiting fetch; any fetch grant or an
  // absent fetch request at an arbitration slot resets the count
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (arbSlot) begin
      if (grantIf || !if_req_i) begin
        starveCnt_d = '0;
      end else if (grantD && (starveCnt_q != 4'hF)) begin
        starveCnt_d = starveCnt_q + 4'd1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  // Strict data priority: a fetch is granted only when no data request exists
  always_comb begin
    grantIf = if_req_i && !d_req_i;
  end
`endif

  assign grantD = d_req_i && !grantIf;

  // Access sequencer: latches the winner, strobes the memory once, waits
  // MEM_LAT cycles, then presents the return for one cycle while re-arbitrating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ownerIf_q   <= 1'b0;
      dWe_q       <= 1'b0;
      latCnt_q    <= '0;
      flush_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          flush_q <= 1'b0;
          if (grantIf) begin
            ownerIf_q  <= 1'b1;
            dWe_q      <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= if_addr_i;
            if_gnt_q   <= 1'b1;
            state_q    <= ISSUE;
          end else if (grantD) begin
            ownerIf_q   <= 1'b0;
            dWe_q       <= d_we_i;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            d_gnt_q     <= 1'b1;
            state_q     <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (ownerIf_q && if_flush_i) begin
            flush_q <= 1'b1;
          end
          latCnt_q <= LatInit;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (ownerIf_q && if_flush_i) begin
            flush_q <= 1'b1;
          end
          if (latCnt_q == 3'd1) begin
            state_q <= DONE;
            if (ownerIf_q) begin
              if (!flush_q && !if_flush_i) begin
                if_valid_q <= 1'b1;
                if_rdata_q <= mem_rdata_i;
              end
            end else begin
              d_valid_q <= 1'b1;
              d_rdata_q <= dWe_q ? '0 : mem_rdata_i;
            end
          end else begin
            latCnt_q <= latCnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A branch taken in the return cycle itself still kills the fetch return
  assign if_valid_o  = if_valid_q && !if_flush_i;
  assign if_gnt_o    = if_gnt_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a 1-cycle
// latency memory model. Grant-order expectations follow MEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:1023];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_valid_o(d_valid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single-port memory, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [AW-1:0] da, input logic [DW-1:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hard stop in case something wedges the sequence
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  logic [9:0] expOrder;
  int grants;
  int cyc;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[3]  = 32'h00000033;
    mem[5]  = 32'h2800000A;
    mem[7]  = 32'h77777777;
    mem[9]  = 32'h00000099;
    mem[12] = 32'h0000C0DE;
    mem[20] = 32'h55AA55AA;
`ifdef MEM_ARB_STARVE_GUARD_EN
    expOrder = 10'b10_0001_0000;
`else
    expOrder = 10'b00_0000_0000;
`endif

    // Reset state
    @(negedge clk); @(negedge clk);
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_d_valid", d_valid, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_busy", busy, 0);

    // IF read of address 5
    rst_n = 1'b1;
    applyStimulus(1, 10'd5, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("if1_gnt", if_gnt, 1);
    checkOutput("if1_d_gnt", d_gnt, 0);
    checkOutput("if1_mem_en", mem_en, 1);
    checkOutput("if1_mem_addr", mem_addr, 5);
    checkOutput("if1_mem_we", mem_we, 0);
    checkOutput("if1_busy", busy, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("if1_mem_en_c2", mem_en, 0);
    checkOutput("if1_valid_c2", if_valid, 0);
    @(negedge clk);
    checkOutput("if1_valid_c3", if_valid, 1);
    checkOutput("if1_rdata", if_rdata, 32'h2800000A);
    @(negedge clk);
    checkOutput("if1_valid_c4", if_valid, 0);
    checkOutput("if1_busy_c4", busy, 0);

    // Load from 20 then store to 20
    applyStimulus(0, 10'd0, 1, 0, 10'd20, 0);
    @(negedge clk);
    checkOutput("ld_gnt", d_gnt, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk); @(negedge clk);
    checkOutput("ld_valid", d_valid, 1);
    checkOutput("ld_rdata", d_rdata, 32'h55AA55AA);
    @(negedge clk);
    applyStimulus(0, 10'd0, 1, 1, 10'd20, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("st_gnt", d_gnt, 1);
    checkOutput("st_mem_en", mem_en, 1);
    checkOutput("st_mem_we", mem_we, 1);
    checkOutput("st_mem_addr", mem_addr, 20);
    checkOutput("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("st_mem_en_c2", mem_en, 0);
    checkOutput("st_valid_c2", d_valid, 0);
    @(negedge clk);
    checkOutput("st_valid", d_valid, 1);
    checkOutput("st_rdata", d_rdata, 0);
    checkOutput("st_mem20", mem[20], 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("st_busy_end", busy, 0);

    // Simultaneous requests: data first, fetch at next slot
    applyStimulus(1, 10'd9, 1, 0, 10'd3, 0);
    @(negedge clk);
    checkOutput("both_d_gnt", d_gnt, 1);
    checkOutput("both_if_gnt_c1", if_gnt, 0);
    applyStimulus(1, 10'd9, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("both_if_gnt_c2", if_gnt, 0);
    @(negedge clk);
    checkOutput("both_d_valid", d_valid, 1);
    checkOutput("both_d_rdata", d_rdata, 32'h00000033);
    checkOutput("both_if_gnt_c3", if_gnt, 0);
    @(negedge clk);
    checkOutput("both_if_gnt_c4", if_gnt, 1);
    checkOutput("both_d_gnt_c4", d_gnt, 0);
    checkOutput("both_mem_addr", mem_addr, 9);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk); @(negedge clk);
    checkOutput("both_if_valid", if_valid, 1);
    checkOutput("both_if_rdata", if_rdata, 32'h00000099);
    @(negedge clk);

    // Flushed fetch of address 7, then a normal fetch of address 12
    applyStimulus(1, 10'd7, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("fl_gnt", if_gnt, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    checkOutput("fl_valid_c2", if_valid, 0);
    @(negedge clk);
    checkOutput("fl_valid_c3", if_valid, 0);
    checkOutput("fl_rdata_kept", if_rdata, 32'h00000099);
    checkOutput("fl_busy_c3", busy, 1);
    @(negedge clk);
    checkOutput("fl_busy_c4", busy, 0);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    applyStimulus(1, 10'd12, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("fl2_gnt", if_gnt, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk); @(negedge clk);
    checkOutput("fl2_valid", if_valid, 1);
    checkOutput("fl2_rdata", if_rdata, 32'h0000C0DE);
    @(negedge clk);

    // Both requests held: grant order
    applyStimulus(1, 10'd9, 1, 0, 10'd3, 0);
    grants = 0;
    cyc = 0;
    while (grants < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      checkOutput("gnt_excl", {31'b0, if_gnt & d_gnt}, 0);
      if (if_gnt || d_gnt) begin
        checkOutput($sformatf("order%0d_if", grants), if_gnt, expOrder[grants]);
        grants++;
      end
    end
    checkOutput("order_count", grants, 10);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("order_drain", busy, 0);
    @(negedge clk);

    // Reset during WAIT
    applyStimulus(1, 10'd5, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("rw_gnt", if_gnt, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk);
    checkOutput("rw_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_busy", busy, 0);
    checkOutput("rw_mem_en", mem_en, 0);
    checkOutput("rw_if_valid", if_valid, 0);
    checkOutput("rw_if_rdata", if_rdata, 0);
    checkOutput("rw_d_rdata", d_rdata, 0);
    checkOutput("rw_mem_addr", mem_addr, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rw_no_if_valid", if_valid, 0);
      checkOutput("rw_no_d_valid", d_valid, 0);
    end
    applyStimulus(0, 10'd0, 1, 0, 10'd3, 0);
    @(negedge clk);
    checkOutput("rw_new_gnt", d_gnt, 1);
    applyStimulus(0, 10'd0, 0, 0, 10'd0, 0);
    @(negedge clk); @(negedge clk);
    checkOutput("rw_new_valid", d_valid, 1);
    checkOutput("rw_new_rdata", d_rdata, 32'h00000033);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
